nf_mem_port_arb: RTL and testbench

Two-requester arbiter that shares the single CPU memory port between instruction fetch and data load/store. Instruction fetch (I) and the load/store path (D) each present a level request and receive an acknowledge. The arbiter grants one requester at a time, registers its address, write data and write enable onto the memory bus, and returns the read data and acknowledge. A watchdog terminates transfers that the memory never acknowledges, and both requesters stall on their acknowledge.

---
 rtl/nf_mem_port_arb.sv | 176 +++++++++++++++++
 tb/tb_nf_mem_port_arb.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nf_mem_port_arb.sv
// -----------------------------------------------------------------------------
// nf_mem_port_arb
//
// Shares the single CPU memory port between instruction fetch (I) and the
// load/store path (D). One requester is granted at a time. The granted
// request's address, write data and write enable are registered onto the
// memory bus. Read data and the acknowledge are returned to that requester.
// A watchdog force-completes a transfer that the memory never acknowledges.
//
// Parameters
//   ADDR_W   address width
//   DATA_W   data width
//   TIMEOUT  maximum cycles bus_req may stay high without bus_ack (0 = off)
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   i_req, i_addr               fetch request (level) and address
//   i_rd, i_ack, i_err          fetch read data, completion pulse, timeout flag
//   d_req, d_we, d_addr, d_wd   data request, store enable, address, store data
//   d_rd, d_ack, d_err          load data, completion pulse, timeout flag
//   bus_req, bus_we             registered memory request and write enable
//   bus_addr, bus_wd            registered memory address and write data
//   bus_rd, bus_ack             memory read data and completion pulse
// -----------------------------------------------------------------------------
module nf_mem_port_arb #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rd,
    output logic              i_ack,
    output logic              i_err,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wd,
    output logic [DATA_W-1:0] d_rd,
    output logic              d_ack,
    output logic              d_err,

    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wd,
    input  logic [DATA_W-1:0] bus_rd,
    input  logic              bus_ack
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

    // Watchdog counter: wide enough to hold TIMEOUT, at least one bit.
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t            state_q, state_d;
    gnt_t              last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_d;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wd_d;

    logic busy;
    logic timeout_hit;
    logic xfer_done;
    logic xfer_err;

    // The counter value equal to TIMEOUT-1 marks the TIMEOUT-th cycle with
    // bus_req high; completion is forced in that cycle. A real bus_ack in the
    // same cycle wins, so err is reported only when the memory stayed silent.
    assign busy        = (state_q == BUSY_I) || (state_q == BUSY_D);
    assign timeout_hit = (TIMEOUT != 0) && busy && (cnt_q == CNT_LAST);
    assign xfer_done   = busy && (bus_ack || timeout_hit);
    assign xfer_err    = busy && !bus_ack && timeout_hit;

    assign i_ack = (state_q == BUSY_I) && xfer_done;
    assign i_err = (state_q == BUSY_I) && xfer_err;
    assign d_ack = (state_q == BUSY_D) && xfer_done;
    assign d_err = (state_q == BUSY_D) && xfer_err;

    // Read data is passed through untouched; each requester qualifies it
    // with its own ack.
    assign i_rd = bus_rd;
    assign d_rd = bus_rd;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        cnt_d      = cnt_q;
        req_d      = bus_req;
        we_d       = bus_we;
        addr_d     = bus_addr;
        wd_d       = bus_wd;

        case (state_q)
            IDLE: begin
                // D wins a tie only when I had the previous grant, so two
                // continuously requesting masters alternate.
                if (d_req && (!i_req || last_gnt_q == GNT_I)) begin
                    state_d    = BUSY_D;
                    last_gnt_d = GNT_D;
                    cnt_d      = '0;
                    req_d      = 1'b1;
                    we_d       = d_we;
                    addr_d     = d_addr;
                    wd_d       = d_wd;
                end else if (i_req) begin
                    state_d    = BUSY_I;
                    last_gnt_d = GNT_I;
                    cnt_d      = '0;
                    req_d      = 1'b1;
                    we_d       = 1'b0;
                    addr_d     = i_addr;
                    wd_d       = '0;
                end
            end

            BUSY_I, BUSY_D: begin
                if (xfer_done) begin
                    // Always pass through IDLE: the ack cycle never grants,
                    // so a still-held req is not served twice.
                    state_d = IDLE;
                    req_d   = 1'b0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            last_gnt_q <= GNT_I;
            cnt_q      <= '0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wd     <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            cnt_q      <= cnt_d;
            bus_req    <= req_d;
            bus_we     <= we_d;
            bus_addr   <= addr_d;
            bus_wd     <= wd_d;
        end
    end

endmodule

// File: tb/tb_nf_mem_port_arb.sv
// -----------------------------------------------------------------------------
// tb_nf_mem_port_arb
//
// Directed bench for nf_mem_port_arb (TIMEOUT=4). Inputs change 1 ns after a
// rising edge; outputs are checked after they settle, away from the edge.
// -----------------------------------------------------------------------------
module tb_nf_mem_port_arb;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rd;
    logic              i_ack;
    logic              i_err;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wd;
    logic [DATA_W-1:0] d_rd;
    logic              d_ack;
    logic              d_err;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wd;
    logic [DATA_W-1:0] bus_rd;
    logic              bus_ack;

    int n_checks = 0;
    int n_errors = 0;

    nf_mem_port_arb #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rd    (i_rd),
        .i_ack   (i_ack),
        .i_err   (i_err),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wd    (d_wd),
        .d_rd    (d_rd),
        .d_ack   (d_ack),
        .d_err   (d_err),
        .bus_req (bus_req),
        .bus_we  (bus_we),
        .bus_addr(bus_addr),
        .bus_wd  (bus_wd),
        .bus_rd  (bus_rd),
        .bus_ack (bus_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [ADDR_W-1:0] exp_addr;
    logic              exp_is_d;

    initial begin
        reset   = 1'b1;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wd    = '0;
        bus_rd  = '0;
        bus_ack = 1'b0;

        // ---------------- reset state ----------------
        #2;
        chk("rst_bus_req",  bus_req,  1'b0);
        chk("rst_bus_we",   bus_we,   1'b0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_wd",   bus_wd,   32'h0);
        chk("rst_acks",     {i_ack, i_err, d_ack, d_err}, 4'b0000);
        step();
        reset = 1'b0;
        step();

        // ---------------- single fetch, ack in 3rd bus_req cycle ----------
        i_req  = 1'b1;
        i_addr = 32'h0000_0100;
        step();                                   // grant edge
        chk("f_bus_req",  bus_req,  1'b1);
        chk("f_bus_addr", bus_addr, 32'h0000_0100);
        chk("f_bus_we",   bus_we,   1'b0);
        chk("f_ack_c1",   i_ack,    1'b0);
        step();
        chk("f_ack_c2",   i_ack,    1'b0);
        step();
        bus_ack = 1'b1;
        bus_rd  = 32'h0010_0093;
        #1;
        chk("f_i_ack",    i_ack,    1'b1);
        chk("f_i_rd",     i_rd,     32'h0010_0093);
        chk("f_i_err",    i_err,    1'b0);
        chk("f_d_ack",    d_ack,    1'b0);
        step();
        bus_ack = 1'b0;
        i_req   = 1'b0;
        #1;
        chk("f_post_req", bus_req,  1'b0);
        chk("f_post_ack", i_ack,    1'b0);

        // ---------------- store, ack in 2nd bus_req cycle ----------------
        d_req  = 1'b1;
        d_we   = 1'b1;
        d_addr = 32'h0000_2000;
        d_wd   = 32'hDEAD_BEEF;
        step();
        chk("s_bus_req",  bus_req,  1'b1);
        chk("s_bus_we",   bus_we,   1'b1);
        chk("s_bus_addr", bus_addr, 32'h0000_2000);
        chk("s_bus_wd",   bus_wd,   32'hDEAD_BEEF);
        chk("s_ack_c1",   d_ack,    1'b0);
        step();
        bus_ack = 1'b1;
        #1;
        chk("s_d_ack",    d_ack,    1'b1);
        chk("s_d_err",    d_err,    1'b0);
        chk("s_i_ack",    i_ack,    1'b0);
        step();
        bus_ack = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        #1;
        chk("s_post_ack", d_ack,    1'b0);
        chk("s_post_req", bus_req,  1'b0);

        // ---------------- simultaneous requests after reset ----------------
        reset = 1'b1;
        #2;
        reset = 1'b0;
        i_req  = 1'b1;
        i_addr = 32'h0000_0400;
        d_req  = 1'b1;
        d_addr = 32'h0000_3000;
        // Expected grant order D, I, D, I; each requester presents a new
        // address in the IDLE cycle after its ack.
        for (int k = 0; k < 4; k++) begin
            exp_is_d = (k % 2 == 0);
            exp_addr = exp_is_d ? (32'h0000_3000 + 32'(4 * (k / 2)))
                                : (32'h0000_0400 + 32'(4 * (k / 2)));
            step();                               // grant edge
            chk($sformatf("arb%0d_addr", k), bus_addr, exp_addr);
            chk($sformatf("arb%0d_req", k),  bus_req,  1'b1);
            bus_ack = 1'b1;
            #1;
            chk($sformatf("arb%0d_acks", k), {d_ack, i_ack}, exp_is_d ? 2'b10 : 2'b01);
            step();                               // ack edge -> IDLE
            bus_ack = 1'b0;
            if (exp_is_d) d_addr = d_addr + 32'd4;
            else          i_addr = i_addr + 32'd4;
            #1;
            chk($sformatf("arb%0d_idle", k), bus_req, 1'b0);
        end
        i_req = 1'b0;
        d_req = 1'b0;
        step();

        // ---------------- watchdog timeout, TIMEOUT=4 ----------------
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h0000_5000;
        step();
        chk("t_bus_req",  bus_req, 1'b1);
        chk("t_ack_c1",   d_ack,   1'b0);
        step();
        chk("t_ack_c2",   d_ack,   1'b0);
        step();
        chk("t_ack_c3",   d_ack,   1'b0);
        step();
        chk("t_ack_c4",   {d_ack, d_err}, 2'b11);
        chk("t_i_side",   {i_ack, i_err}, 2'b00);
        step();
        d_req = 1'b0;
        #1;
        chk("t_post_req", bus_req, 1'b0);
        chk("t_post_ack", {d_ack, d_err}, 2'b00);
        step();
        chk("t_idle_req", bus_req, 1'b0);

        // ---------------- async reset while BUSY_I ----------------
        i_req  = 1'b1;
        i_addr = 32'h0000_0600;
        step();
        chk("r_bus_req",  bus_req, 1'b1);
        #1;
        reset = 1'b1;
        #1;                                       // no clock edge in between
        chk("r_async",    bus_req, 1'b0);
        chk("r_no_ack",   i_ack,   1'b0);
        i_req = 1'b0;
        #1;
        reset = 1'b0;
        step();
        bus_ack = 1'b1;
        #1;
        chk("r_late_ack", {i_ack, i_err, d_ack, d_err}, 4'b0000);
        step();
        bus_ack = 1'b0;
        #1;
        chk("r_idle_req", bus_req, 1'b0);

        // ---------------- spurious bus_ack in IDLE ----------------
        bus_ack = 1'b1;
        #1;
        chk("sp_acks",    {i_ack, d_ack}, 2'b00);
        step();
        bus_ack = 1'b0;
        #1;
        chk("sp_bus_req", bus_req, 1'b0);
        chk("sp_acks2",   {i_ack, d_ack}, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
